// File: rtl/instruction_encoder.sv
// Streaming packer: classifies decoded instruction fields, packs them into the 32-bit ISA word
// and emits them with sequential imem addresses. Optional: ENCODER_IMM_RANGE_CHECK_EN.
module instruction_encoder #(
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [4:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_shamt,
   input  logic [4:0]        in_aluop,
   input  logic [31:0]       in_imm,
   input  logic [26:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_ins,
   output logic [ADDR_W-1:0] out_addr,
   output logic [7:0]        err_count,
   output logic              err_flag,
   output logic              done
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
   typedef enum logic [2:0] {CLS_R, CLS_I, CLS_JI, CLS_JII, CLS_BAD} class_e;

   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_ins_q, out_ins_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic [7:0]        err_count_q, err_count_d;
   logic              err_flag_q, err_flag_d;

   class_e            op_class;
   logic              imm_ok;
   logic              bundle_legal;
   logic [31:0]       packed_ins;
   logic              accept;
   logic              start_ok;
   logic              last_slot;

   always_comb begin
      op_class = CLS_BAD;
      case (in_opcode)
         5'b00000:                      op_class = CLS_R;
         5'b00101, 5'b00111, 5'b01000,
         5'b00010, 5'b00110, 5'b10001:  op_class = CLS_I;
         5'b00001, 5'b00011,
         5'b10110, 5'b10101:            op_class = CLS_JI;
         5'b00100:                      op_class = CLS_JII;
         default:                       op_class = CLS_BAD;
      endcase
   end

`ifdef ENCODER_IMM_RANGE_CHECK_EN
   // In range exactly when the upper bits are a sign extension of bit 16.
   assign imm_ok = (in_imm[31:16] == {16{in_imm[16]}});
`else
   logic unused_imm_hi;
   assign unused_imm_hi = ^in_imm[31:17];
   assign imm_ok        = 1'b1;
`endif

   assign bundle_legal = (op_class != CLS_BAD) && ((op_class != CLS_I) || imm_ok);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      packed_ins        = '0;
      packed_ins[31:27] = in_opcode;
      case (op_class)
         CLS_R:   packed_ins[26:2]  = {in_rd, in_rs, in_rt, in_shamt, in_aluop};
         CLS_I:   packed_ins[26:0]  = {in_rd, in_rs, in_imm[16:0]};
         CLS_JI:  packed_ins[26:0]  = in_target;
         CLS_JII: packed_ins[26:22] = in_rd;
         default: packed_ins[26:0]  = '0;
      endcase
   end

   assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign start_ok  = start && (state_q != ST_RUN) && !out_valid_q;
   assign last_slot = (addr_cnt_q == ADDR_W'(DEPTH - 1));

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      out_ins_d   = out_ins_q;
      out_addr_d  = out_addr_q;
      addr_cnt_d  = addr_cnt_q;
      err_count_d = err_count_q;
      err_flag_d  = err_flag_q;

      if (start_ok) begin
         state_d     = ST_RUN;
         addr_cnt_d  = '0;
         err_count_d = '0;
         err_flag_d  = 1'b0;
      end else if (accept) begin
         if (bundle_legal) begin
            out_valid_d = 1'b1;
            out_ins_d   = packed_ins;
            out_addr_d  = addr_cnt_q;
            addr_cnt_d  = addr_cnt_q + 1'b1;
            if (in_last || last_slot) state_d = ST_DONE;
         end else begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            err_flag_d = 1'b1;
            if (in_last) state_d = ST_DONE;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_ins_q   <= '0;
         out_addr_q  <= '0;
         addr_cnt_q  <= '0;
         err_count_q <= '0;
         err_flag_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_ins_q   <= out_ins_d;
         out_addr_q  <= out_addr_d;
         addr_cnt_q  <= addr_cnt_d;
         err_count_q <= err_count_d;
         err_flag_q  <= err_flag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ins   = out_ins_q;
   assign out_addr  = out_addr_q;
   assign err_count = err_count_q;
   assign err_flag  = err_flag_q;
   assign done      = (state_q == ST_DONE) && !out_valid_q;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming instruction packer for the program-load path: accepts decoded instruction fields over a valid/ready handshake and classifies the opcode into R, I, JI or JII. Packs legal instructions into the 32-bit ISA word and emits them with a sequential instruction-memory address. It is the inverse of the opcode-class decode in the processor front end. Sits between the test/boot loader and the instruction-memory write port.

## Interface
- `DEPTH`, default 4096: maximum instructions per load session.
- `ADDR_W`, default 12: width of `out_addr`; DEPTH ≤ 2^ADDR_W.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: begin load session (pulse).
- `in_valid` in 1: field bundle valid.
- `in_ready` out 1: bundle accepted when `in_valid && in_ready`.
- `in_last` in 1: final bundle of session.
- `in_opcode` in 5: opcode.
- `in_rd`, `in_rs`, `in_rt` in 5 each: register fields.
- `in_shamt`, `in_aluop` in 5 each: R-type fields.
- `in_imm` in 32: signed immediate (I-type).
- `in_target` in 27: jump target (JI-type).
- `out_valid` out 1: packed word valid.
- `out_ready` in 1: downstream accepts word.
- `out_ins` out 32: packed instruction.
- `out_addr` out ADDR_W: imem address for `out_ins`.
- `err_count` out 8: rejected bundles this session, saturating at 255.
- `err_flag` out 1: sticky, set on any rejection.
- `done` out 1: session complete, output drained.

## Operation
- Opcode classes:
  - R: 00000.
  - I: 00101, 00111, 01000, 00010, 00110, 10001.
  - JI: 00001, 00011, 10110, 10101.
  - JII: 00100.
  - Any other opcode is illegal.
- Packing, with `opcode` always in [31:27]:
  - R: rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], [1:0]=0.
  - I: rd[26:22], rs[21:17], imm[16:0].
  - JI: target[26:0].
  - JII: rd[26:22], [21:0]=0.
  - Unused input fields are ignored.
- FSM states IDLE, RUN, DONE.
  - IDLE/DONE → RUN on `start` while `out_valid`=0. Start clears the address counter to 0, `err_count` to 0 and `err_flag` to 0.
  - `start` is ignored in RUN or while `out_valid`=1.
  - RUN → DONE on acceptance of a bundle with `in_last`=1, whether the bundle is legal or rejected.
  - RUN → DONE on acceptance of the DEPTH-th legal bundle.
- `in_ready` = (state==RUN) && (!out_valid || out_ready).
- Legal bundle accepted:
  - Output register loads `out_ins`, and `out_addr` = current counter.
  - Counter increments.
- Rejected bundle accepted:
  - Consumed without any output.
  - Counter unchanged.
  - `err_count` increments with saturation; `err_flag` sets.
- `done` = (state==DONE) && !out_valid.

## Timing
- Reset values: state IDLE, `in_ready` 0, `out_valid` 0, `out_ins` 0, `out_addr` 0, `err_count` 0, `err_flag` 0, `done` 0.
- Latency: a bundle accepted at edge N presents `out_valid`/`out_ins` after edge N, i.e. in cycle N+1.
- Output register is one deep. Full throughput of one per cycle holds while `out_ready`=1.
- Under output stall (`out_valid && !out_ready`):
  - `out_ins` and `out_addr` are held stable.
  - `in_ready`=0.
- Same cycle `out_ready` and new accept: the register reloads with no bubble.
- `start` is registered: state is RUN and `in_ready` can be 1 from the cycle after the start pulse.
- Rejection on the last bundle: DONE, with no output produced.
- Counter wrap cannot occur, because DEPTH terminates the session first.
- `reset_n` low mid-session: all state returns to reset values at the next edge, and any pending word is discarded.

## Configuration
- `ENCODER_IMM_RANGE_CHECK_EN` defined:
  - An I-type bundle whose `in_imm` lies outside the signed 17-bit range [-65536, 65535] is rejected, counting as an error.
- Not defined:
  - `in_imm[16:0]` is packed with silent truncation.
  - Only illegal opcodes are rejected.

## Test plan
- Reset low 3 cycles then high → all outputs 0 and `in_ready`=0. Then start → `in_ready`=1 next cycle.
- Three legal bundles, `out_ready`=1, last flagged on the third:
  - addi rd1 rs0 imm5 → 0x28400005 at addr 0.
  - add rd3 rs1 rt2 → 0x00C22000 at addr 1.
  - j target 100 → 0x08000064 at addr 2.
  - Then `done`=1.
- jr rd31 → 0x27C00000. Then addi rd1 imm -1 → 0x2841FFFF.
- Opcode 11111 between two legal bundles:
  - `err_count`=1, `err_flag`=1.
  - Legal addresses are 0 and 1, with no gap.
- Hold `out_ready`=0 for 4 cycles with `in_valid`=1:
  - `out_ins` stable, `in_ready`=0.
  - Release → no loss or duplication.
- addi imm 70000:
  - With macro → rejected, `err_count`=1.
  - Without macro → packs 0x28411170.
